// File: rtl/spi_slave_word_if.sv
// Word-level handshake bundle for spi_slave_word: TX holding-register write
// port, received-word strobe and frame status flags.
interface spi_slave_word_if #(
    parameter int WORD_WIDTH = 16
);
    logic                  i_TX_DV;
    logic [WORD_WIDTH-1:0] i_TX_Word;
    logic                  o_TX_Ready;
    logic                  o_TX_Underrun;
    logic                  o_RX_DV;
    logic [WORD_WIDTH-1:0] o_RX_Word;
    logic                  o_Frame_Error;
    logic                  o_Busy;

    // Seen from the SPI slave block.
    modport slave (
        input  i_TX_DV,
        input  i_TX_Word,
        output o_TX_Ready,
        output o_TX_Underrun,
        output o_RX_DV,
        output o_RX_Word,
        output o_Frame_Error,
        output o_Busy
    );

    // Seen from the local logic that feeds and drains the slave.
    modport master (
        output i_TX_DV,
        output i_TX_Word,
        input  o_TX_Ready,
        input  o_TX_Underrun,
        input  o_RX_DV,
        input  o_RX_Word,
        input  o_Frame_Error,
        input  o_Busy
    );
endinterface

// File: rtl/spi_slave_word.sv
// SPI slave, word oriented, all four SPI modes. SPI pins are oversampled on
// i_Clk through 2-flop synchronisers; words are exchanged MSB first and may
// run back to back for as long as CS_n stays low.
module spi_slave_word #(
    parameter int SPI_MODE   = 0,
    parameter int WORD_WIDTH = 16
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    spi_slave_word_if.slave       bus,
    input  logic                  i_SPI_Clk,
    input  logic                  i_SPI_MOSI,
    input  logic                  i_SPI_CS_n,
    output logic                  o_SPI_MISO
);

    localparam logic CPOL = (SPI_MODE >= 2);
    localparam logic CPHA = ((SPI_MODE % 2) == 1);
    localparam int   CW   = $clog2(WORD_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WORD_WIDTH - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    // Synchroniser and edge-history registers
    logic                  r_SCLK_Meta, r_SCLK_Sync, r_SCLK_Prev;
    logic                  r_CS_Meta, r_CS_Sync, r_CS_Prev;
    logic                  r_MOSI_Meta, r_MOSI_Sync;
    logic [1:0]            r_Sync_Cnt;

    // Core state
    logic [0:0]            r_State;
    logic [CW-1:0]         r_Bit_Cnt;
    logic [WORD_WIDTH-1:0] r_RX_Shift;
    logic [WORD_WIDTH-1:0] r_RX_Word;
    logic                  r_RX_DV;
    logic [WORD_WIDTH-1:0] r_TX_Shift;
    logic [WORD_WIDTH-1:0] r_TX_Hold;
    logic                  r_TX_Full;
    logic                  r_TX_Underrun;
    logic                  r_Frame_Error;

    // Decoded events
    logic                  w_Sync_Valid;
    logic                  w_CS_Fall, w_CS_Rise;
    logic                  w_Lead, w_Trail;
    logic                  w_Sample, w_Shift;
    logic                  w_Active_Ev;
    logic                  w_Sample_Ev, w_Shift_Ev;
    logic                  w_Word_Done;
    logic                  w_Start;
    logic                  w_TX_Load;
    logic                  w_TX_Write;
    logic [WORD_WIDTH-1:0] w_RX_Next;

    // Bring the asynchronous SPI pins into the i_Clk domain and keep one
    // extra sample of SCLK/CS_n for edge detection.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_SCLK_Meta <= CPOL;
            r_SCLK_Sync <= CPOL;
            r_SCLK_Prev <= CPOL;
            r_CS_Meta   <= 1'b1;
            r_CS_Sync   <= 1'b1;
            r_CS_Prev   <= 1'b1;
            r_MOSI_Meta <= 1'b0;
            r_MOSI_Sync <= 1'b0;
            r_Sync_Cnt  <= '0;
        end else begin
            r_SCLK_Meta <= i_SPI_Clk;
            r_SCLK_Sync <= r_SCLK_Meta;
            r_SCLK_Prev <= r_SCLK_Sync;
            r_CS_Meta   <= i_SPI_CS_n;
            r_CS_Sync   <= r_CS_Meta;
            r_CS_Prev   <= r_CS_Sync;
            r_MOSI_Meta <= i_SPI_MOSI;
            r_MOSI_Sync <= r_MOSI_Meta;
            if (r_Sync_Cnt != 2'd3) begin
                r_Sync_Cnt <= r_Sync_Cnt + 2'd1;
            end
        end
    end

    // The CS_n history only reflects the real pin once three samples have
    // been taken after reset. Until then a CS_n held low through reset would
    // look like a falling edge, so edge detection waits for a genuine one.
    assign w_Sync_Valid = (r_Sync_Cnt == 2'd3);
    assign w_CS_Fall    = w_Sync_Valid &&  r_CS_Prev && !r_CS_Sync;
    assign w_CS_Rise    = w_Sync_Valid && !r_CS_Prev &&  r_CS_Sync;

    assign w_Lead   = (r_SCLK_Prev == CPOL) && (r_SCLK_Sync != CPOL);
    assign w_Trail  = (r_SCLK_Prev != CPOL) && (r_SCLK_Sync == CPOL);
    assign w_Sample = CPHA ? w_Trail : w_Lead;
    assign w_Shift  = CPHA ? w_Lead  : w_Trail;

    // A CS_n rise ends the frame; any SCLK edge seen in that same cycle is
    // discarded along with the partial word.
    assign w_Active_Ev = (r_State == ST_ACTIVE) && !w_CS_Rise;
    assign w_Sample_Ev = w_Active_Ev && w_Sample;
    assign w_Shift_Ev  = w_Active_Ev && w_Shift;
    assign w_Word_Done = w_Sample_Ev && (r_Bit_Cnt == LAST_BIT);
    assign w_Start     = (r_State == ST_IDLE) && w_CS_Fall;
    assign w_TX_Load   = w_Start || w_Word_Done;
    assign w_TX_Write  = bus.i_TX_DV && !r_TX_Full;
    assign w_RX_Next   = {r_RX_Shift[WORD_WIDTH-2:0], r_MOSI_Sync};

    // Frame FSM: ACTIVE for as long as synced CS_n stays low.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_State <= ST_IDLE;
        end else begin
            case (r_State)
                ST_IDLE:   if (w_CS_Fall) r_State <= ST_ACTIVE;
                ST_ACTIVE: if (w_CS_Rise) r_State <= ST_IDLE;
                default:   r_State <= ST_IDLE;
            endcase
        end
    end

    // Bit position within the current word, advanced on each sample edge.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_Bit_Cnt <= '0;
        end else if (w_Start) begin
            r_Bit_Cnt <= '0;
        end else if (w_Sample_Ev) begin
            if (r_Bit_Cnt == LAST_BIT) begin
                r_Bit_Cnt <= '0;
            end else begin
                r_Bit_Cnt <= r_Bit_Cnt + 1'b1;
            end
        end
    end

    // Receive shifter; a completed word is published with a one-cycle strobe.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_RX_Shift <= '0;
            r_RX_Word  <= '0;
            r_RX_DV    <= 1'b0;
        end else begin
            r_RX_DV <= 1'b0;
            if (w_Sample_Ev) begin
                r_RX_Shift <= w_RX_Next;
                if (r_Bit_Cnt == LAST_BIT) begin
                    r_RX_Word <= w_RX_Next;
                    r_RX_DV   <= 1'b1;
                end
            end
        end
    end

    // Transmit shifter. The first shift edge of each word is skipped because
    // its MSB was already presented at load time.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_TX_Shift <= '0;
        end else if (w_TX_Load) begin
            r_TX_Shift <= r_TX_Full ? r_TX_Hold : '0;
        end else if (w_Shift_Ev && (r_Bit_Cnt != '0)) begin
            r_TX_Shift <= {r_TX_Shift[WORD_WIDTH-2:0], 1'b0};
        end
    end

    // Single-entry TX holding register. A write landing in the same cycle as
    // a load from an empty register refills it after the load took zeros.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_TX_Hold <= '0;
            r_TX_Full <= 1'b0;
        end else if (w_TX_Write) begin
            r_TX_Hold <= bus.i_TX_Word;
            r_TX_Full <= 1'b1;
        end else if (w_TX_Load) begin
            r_TX_Full <= 1'b0;
        end
    end

    // One-cycle status pulses: TX underrun and CS_n lost mid-word.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            r_TX_Underrun <= 1'b0;
            r_Frame_Error <= 1'b0;
        end else begin
            r_TX_Underrun <= w_TX_Load && !r_TX_Full;
            r_Frame_Error <= (r_State == ST_ACTIVE) && w_CS_Rise && (r_Bit_Cnt != '0);
        end
    end

    assign bus.o_RX_DV       = r_RX_DV;
    assign bus.o_RX_Word     = r_RX_Word;
    assign bus.o_TX_Ready    = !r_TX_Full;
    assign bus.o_TX_Underrun = r_TX_Underrun;
    assign bus.o_Frame_Error = r_Frame_Error;
    assign bus.o_Busy        = (r_State == ST_ACTIVE);

    // MISO is released whenever the raw chip select is inactive.
    assign o_SPI_MISO = i_SPI_CS_n ? 1'bz : r_TX_Shift[WORD_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_word.sv
// Directed bench for spi_slave_word: four instances cover modes 0/3/1/2,
// each driven by a bit-level SPI master running at i_Clk/16.
module tb_spi_slave_word;

    logic        r_Clk;
    logic        r_Rst;
    logic [3:0]  r_Sclk;
    logic [3:0]  r_Mosi;
    logic [3:0]  r_Csn;
    logic [3:0]  r_TxDv;
    logic [31:0] r_TxWord [4];
    logic        w_Miso0, w_Miso1, w_Miso2, w_Miso3;
    logic [3:0]  w_RxDv, w_Und, w_Fe, w_Busy, w_Ready;

    int n_checks = 0;
    int n_fail   = 0;

    int dv_cnt    [4] = '{0, 0, 0, 0};
    int und_cnt   [4] = '{0, 0, 0, 0};
    int fe_cnt    [4] = '{0, 0, 0, 0};
    int und_at_dv [4] = '{0, 0, 0, 0};
    logic [31:0] word_last [4] = '{32'd0, 32'd0, 32'd0, 32'd0};
    logic [31:0] word_prev [4] = '{32'd0, 32'd0, 32'd0, 32'd0};

    spi_slave_word_if #(.WORD_WIDTH(16)) u_if0 ();
    spi_slave_word_if #(.WORD_WIDTH(16)) u_if1 ();
    spi_slave_word_if #(.WORD_WIDTH(8))  u_if2 ();
    spi_slave_word_if #(.WORD_WIDTH(16)) u_if3 ();

    spi_slave_word #(.SPI_MODE(0), .WORD_WIDTH(16)) u_dut0 (
        .i_Clk(r_Clk), .i_Rst(r_Rst), .bus(u_if0.slave),
        .i_SPI_Clk(r_Sclk[0]), .i_SPI_MOSI(r_Mosi[0]), .i_SPI_CS_n(r_Csn[0]),
        .o_SPI_MISO(w_Miso0));
    spi_slave_word #(.SPI_MODE(3), .WORD_WIDTH(16)) u_dut1 (
        .i_Clk(r_Clk), .i_Rst(r_Rst), .bus(u_if1.slave),
        .i_SPI_Clk(r_Sclk[1]), .i_SPI_MOSI(r_Mosi[1]), .i_SPI_CS_n(r_Csn[1]),
        .o_SPI_MISO(w_Miso1));
    spi_slave_word #(.SPI_MODE(1), .WORD_WIDTH(8)) u_dut2 (
        .i_Clk(r_Clk), .i_Rst(r_Rst), .bus(u_if2.slave),
        .i_SPI_Clk(r_Sclk[2]), .i_SPI_MOSI(r_Mosi[2]), .i_SPI_CS_n(r_Csn[2]),
        .o_SPI_MISO(w_Miso2));
    spi_slave_word #(.SPI_MODE(2), .WORD_WIDTH(16)) u_dut3 (
        .i_Clk(r_Clk), .i_Rst(r_Rst), .bus(u_if3.slave),
        .i_SPI_Clk(r_Sclk[3]), .i_SPI_MOSI(r_Mosi[3]), .i_SPI_CS_n(r_Csn[3]),
        .o_SPI_MISO(w_Miso3));

    assign u_if0.i_TX_DV   = r_TxDv[0];
    assign u_if1.i_TX_DV   = r_TxDv[1];
    assign u_if2.i_TX_DV   = r_TxDv[2];
    assign u_if3.i_TX_DV   = r_TxDv[3];
    assign u_if0.i_TX_Word = r_TxWord[0][15:0];
    assign u_if1.i_TX_Word = r_TxWord[1][15:0];
    assign u_if2.i_TX_Word = r_TxWord[2][7:0];
    assign u_if3.i_TX_Word = r_TxWord[3][15:0];

    assign w_RxDv  = {u_if3.o_RX_DV, u_if2.o_RX_DV, u_if1.o_RX_DV, u_if0.o_RX_DV};
    assign w_Und   = {u_if3.o_TX_Underrun, u_if2.o_TX_Underrun, u_if1.o_TX_Underrun, u_if0.o_TX_Underrun};
    assign w_Fe    = {u_if3.o_Frame_Error, u_if2.o_Frame_Error, u_if1.o_Frame_Error, u_if0.o_Frame_Error};
    assign w_Busy  = {u_if3.o_Busy, u_if2.o_Busy, u_if1.o_Busy, u_if0.o_Busy};
    assign w_Ready = {u_if3.o_TX_Ready, u_if2.o_TX_Ready, u_if1.o_TX_Ready, u_if0.o_TX_Ready};

    initial r_Clk = 1'b0;
    always #5 r_Clk = ~r_Clk;

    function automatic logic [31:0] get_rx(int d);
        case (d)
            0:       return {16'd0, u_if0.o_RX_Word};
            1:       return {16'd0, u_if1.o_RX_Word};
            2:       return {24'd0, u_if2.o_RX_Word};
            default: return {16'd0, u_if3.o_RX_Word};
        endcase
    endfunction

    function automatic logic get_miso(int d);
        case (d)
            0:       return w_Miso0;
            1:       return w_Miso1;
            2:       return w_Miso2;
            default: return w_Miso3;
        endcase
    endfunction

    // Pulse monitor, sampled on the falling clock edge.
    always @(negedge r_Clk) begin
        for (int d = 0; d < 4; d++) begin
            if (w_RxDv[d]) begin
                dv_cnt[d]    <= dv_cnt[d] + 1;
                word_prev[d] <= word_last[d];
                word_last[d] <= get_rx(d);
                und_at_dv[d] <= und_cnt[d];
            end
            if (w_Und[d]) und_cnt[d] <= und_cnt[d] + 1;
            if (w_Fe[d])  fe_cnt[d]  <= fe_cnt[d] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tx_write(input int d, input logic [31:0] w);
        @(negedge r_Clk);
        r_TxDv[d]   = 1'b1;
        r_TxWord[d] = w;
        @(negedge r_Clk);
        r_TxDv[d]   = 1'b0;
    endtask

    task automatic cs_low(input int d);
        r_Csn[d] = 1'b0;
        repeat (6) @(negedge r_Clk);
    endtask

    task automatic cs_high(input int d);
        repeat (8) @(negedge r_Clk);
        r_Csn[d] = 1'b1;
        repeat (8) @(negedge r_Clk);
    endtask

    // Master side: drives nbits of data MSB first, samples MISO on the
    // master's sample edge.
    task automatic spi_shift(input int d, input int mode, input int nbits,
                             input logic [63:0] data, output logic [63:0] miso);
        logic cpol, cpha;
        cpol = (mode >= 2);
        cpha = ((mode % 2) == 1);
        miso = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            if (!cpha) begin
                r_Mosi[d] = data[i];
                repeat (8) @(negedge r_Clk);
                r_Sclk[d] = ~cpol;
                miso[i]   = get_miso(d);
                repeat (8) @(negedge r_Clk);
                r_Sclk[d] = cpol;
            end else begin
                r_Sclk[d] = ~cpol;
                r_Mosi[d] = data[i];
                repeat (8) @(negedge r_Clk);
                r_Sclk[d] = cpol;
                miso[i]   = get_miso(d);
                repeat (8) @(negedge r_Clk);
            end
        end
    endtask

    initial begin
        logic [63:0] m;
        int s_dv, s_und, s_fe;

        r_Rst    = 1'b1;
        r_Csn    = 4'hF;
        r_Sclk   = 4'b1010;
        r_Mosi   = 4'h0;
        r_TxDv   = 4'h0;
        for (int d = 0; d < 4; d++) r_TxWord[d] = '0;
        repeat (4) @(negedge r_Clk);

        // Reset state
        chk("rst_ready",  {31'd0, w_Ready[0]}, 32'd1);
        chk("rst_busy",   {28'd0, w_Busy},     32'd0);
        chk("rst_rxdv",   {28'd0, w_RxDv},     32'd0);
        chk("rst_und",    {28'd0, w_Und},      32'd0);
        chk("rst_fe",     {28'd0, w_Fe},       32'd0);
        chk("rst_rxword", get_rx(0),           32'd0);
        r_Rst = 1'b0;
        repeat (5) @(negedge r_Clk);

        // Mode 0, W=16: preload 0xA5C3, receive 0x1234
        tx_write(0, 32'hA5C3);
        chk("m0_ready_full", {31'd0, w_Ready[0]}, 32'd0);
        s_dv = dv_cnt[0];
        cs_low(0);
        chk("m0_busy", {31'd0, w_Busy[0]}, 32'd1);
        spi_shift(0, 0, 16, 64'h1234, m);
        cs_high(0);
        chk("m0_miso",   m[31:0], 32'hA5C3);
        chk("m0_dvcnt",  dv_cnt[0] - s_dv, 32'd1);
        chk("m0_rxword", word_last[0], 32'h1234);
        chk("m0_idle",   {31'd0, w_Busy[0]}, 32'd0);

        // Mode 3, W=16: same stimulus
        tx_write(1, 32'hA5C3);
        s_dv = dv_cnt[1];
        cs_low(1);
        spi_shift(1, 3, 16, 64'h1234, m);
        cs_high(1);
        chk("m3_miso",   m[31:0], 32'hA5C3);
        chk("m3_dvcnt",  dv_cnt[1] - s_dv, 32'd1);
        chk("m3_rxword", word_last[1], 32'h1234);

        // Mode 1, W=8: two back-to-back words, second TX word written mid-frame;
        // a write while the register is full is ignored
        tx_write(2, 32'h81);
        tx_write(2, 32'h33);
        chk("m1_ready_full", {31'd0, w_Ready[2]}, 32'd0);
        s_dv  = dv_cnt[2];
        s_und = und_cnt[2];
        cs_low(2);
        chk("m1_ready_after_load", {31'd0, w_Ready[2]}, 32'd1);
        tx_write(2, 32'h7E);
        spi_shift(2, 1, 16, 64'h55AA, m);
        cs_high(2);
        chk("m1_miso",      m[31:0], 32'h817E);
        chk("m1_dvcnt",     dv_cnt[2] - s_dv, 32'd2);
        chk("m1_word1",     word_prev[2], 32'h55);
        chk("m1_word2",     word_last[2], 32'hAA);
        chk("m1_no_underrun_in_frame", und_at_dv[2] - s_und, 32'd0);
        // the load at the end of word 2 finds the register empty
        chk("m1_und_final", und_cnt[2] - s_und, 32'd1);

        // Mode 0, W=16: empty holding register at CS_n fall
        s_und = und_cnt[0];
        s_dv  = dv_cnt[0];
        cs_low(0);
        chk("m0u_und_pulse", und_cnt[0] - s_und, 32'd1);
        spi_shift(0, 0, 16, 64'hFFFF, m);
        cs_high(0);
        chk("m0u_miso",   m[31:0], 32'h0000);
        chk("m0u_rxword", word_last[0], 32'hFFFF);
        chk("m0u_dvcnt",  dv_cnt[0] - s_dv, 32'd1);

        // Mode 2, W=16: complete frame, then CS_n rises after 5 bits
        s_fe = fe_cnt[3];
        cs_low(3);
        spi_shift(3, 2, 16, 64'h0F0F, m);
        cs_high(3);
        chk("m2_rxword",   get_rx(3), 32'h0F0F);
        chk("m2_fe_clean", fe_cnt[3] - s_fe, 32'd0);
        s_dv = dv_cnt[3];
        cs_low(3);
        spi_shift(3, 2, 5, 64'h16, m);
        cs_high(3);
        chk("m2_fe",     fe_cnt[3] - s_fe, 32'd1);
        chk("m2_no_dv",  dv_cnt[3] - s_dv, 32'd0);
        chk("m2_retain", get_rx(3), 32'h0F0F);

        // Mode 0, W=16: reset after bit 9, then a full frame
        tx_write(0, 32'h1357);
        s_dv = dv_cnt[0];
        s_fe = fe_cnt[0];
        cs_low(0);
        spi_shift(0, 0, 9, 64'h1AB, m);
        r_Rst = 1'b1;
        repeat (2) @(negedge r_Clk);
        chk("rstmid_busy",   {31'd0, w_Busy[0]},  32'd0);
        chk("rstmid_ready",  {31'd0, w_Ready[0]}, 32'd1);
        chk("rstmid_rxword", get_rx(0), 32'd0);
        chk("rstmid_miso",   {31'd0, w_Miso0}, 32'd0);
        r_Rst = 1'b0;
        repeat (10) @(negedge r_Clk);
        chk("rstmid_no_restart", {31'd0, w_Busy[0]}, 32'd0);
        cs_high(0);
        chk("rstmid_no_fe", fe_cnt[0] - s_fe, 32'd0);
        chk("rstmid_no_dv", dv_cnt[0] - s_dv, 32'd0);
        cs_low(0);
        chk("rst_after_busy", {31'd0, w_Busy[0]}, 32'd1);
        spi_shift(0, 0, 16, 64'hBEEF, m);
        cs_high(0);
        chk("rst_after_rxword", get_rx(0), 32'hBEEF);
        chk("rst_after_dv",     dv_cnt[0] - s_dv, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
